fetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder (which embeds the immediate generator).
- Owns the PC and issues reads to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump/trap) that flushes all in-flight and buffered instructions.

---
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : PC owner, 1-cycle imem read issue and FIFO toward decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN.          Rev 1.0
// ============================================================================
module fetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_ren,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        o_misaligned
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic          w_halt;
  logic          w_pop;
  logic          w_enq;
  logic          w_issue;
  logic [CW-1:0] w_occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q, halted_d;

  assign w_halt       = halted_q;
  assign o_misaligned = halted_q;
  assign halted_d     = i_redirect ? (i_redirect_pc[1:0] != 2'b00) : halted_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
`else
  assign w_halt = 1'b0;
`endif

  always_comb begin
    o_inst_valid = (count_q != '0) & ~i_redirect & ~w_halt;
    w_pop        = o_inst_valid & i_inst_ready;
    // Slots already committed: buffered words plus the response still on its way.
    w_occupancy  = count_q + CW'(inflight_q) - CW'(w_pop);
    w_issue      = ~i_rst & ~i_redirect & ~w_halt & (w_occupancy < CW'(DEPTH));
    w_enq        = inflight_q & ~i_redirect;

    pc_d          = pc_q;
    inflight_d    = w_issue;
    inflight_pc_d = w_issue ? pc_q : inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (i_redirect) begin
      pc_d     = i_redirect_pc & 32'hFFFF_FFFC;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (w_issue) pc_d = pc_q + 32'd4;
      if (w_enq)   wr_ptr_d = ptr_inc(wr_ptr_q);
      if (w_pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(w_enq) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q          <= RESET_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (w_enq) begin
      inst_mem_q[wr_ptr_q] <= i_imem_rdata;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign o_imem_ren   = w_issue;
  assign o_imem_raddr = pc_q;
  assign o_inst       = inst_mem_q[rd_ptr_q];
  assign o_inst_pc    = pc_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue : directed + random stimulus against a queue-based fetch model.
module tb_fetch_queue;

  localparam int          TB_DEPTH = 2;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        ready = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
  logic        w_misaligned;
`endif

  logic        w_ren;
  logic [31:0] w_raddr;
  logic [31:0] w_rdata = '0;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_ADDR(32'h0000_0000), .DEPTH(TB_DEPTH)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_ren(ren), .o_imem_raddr(raddr), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_inst_valid(valid), .o_inst(inst), .o_inst_pc(inst_pc),
    .i_inst_ready(ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .o_misaligned(misaligned)
`endif
  );

  fetch_queue #(.RESET_ADDR(32'hFFFF_FFF8), .DEPTH(TB_DEPTH)) u_wrap (
    .i_clk(clk), .i_rst(rst),
    .o_imem_ren(w_ren), .o_imem_raddr(w_raddr), .i_imem_rdata(w_rdata),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_inst_valid(w_valid), .o_inst(w_inst), .o_inst_pc(w_pc),
    .i_inst_ready(1'b1)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .o_misaligned(w_misaligned)
`endif
  );

  // Synchronous instruction memory; garbage when no read is requested.
  always @(posedge clk) begin
    rdata   <= ren   ? (raddr   ^ K) : 32'hDEAD_BEEF;
    w_rdata <= w_ren ? (w_raddr ^ K) : 32'hDEAD_BEEF;
  end

  logic [31:0] wcap [$];
  always @(negedge clk) begin
    if (!rst && w_valid && wcap.size() < 3) wcap.push_back(w_pc);
  end

  int passes = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference model: buffered PCs in order, one outstanding read at most.
  logic [31:0] mq [$];
  bit          m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_pc;
  bit          m_halt;

  logic        s_ren, s_valid;
  logic [31:0] s_raddr, s_pc, s_inst;

  task automatic model_reset();
    mq.delete();
    m_inflight = 0;
    m_pc       = 32'h0;
    m_halt     = 0;
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit exp_valid, exp_pop, exp_ren;
    @(negedge clk);
    redirect = redir; redirect_pc = rpc; ready = rdy;
    #1;
    s_ren = ren; s_raddr = raddr; s_valid = valid; s_pc = inst_pc; s_inst = inst;
    exp_valid = (mq.size() != 0) && !redir && !m_halt;
    exp_pop   = exp_valid && rdy;
    exp_ren   = !redir && !m_halt &&
                ((mq.size() + int'(m_inflight) - int'(exp_pop)) < TB_DEPTH);
    check("inst_valid", valid, exp_valid);
    check("imem_ren", ren, exp_ren);
    if (exp_ren)   check("imem_raddr", raddr, m_pc);
    if (exp_valid) begin
      check("inst_pc", inst_pc, mq[0]);
      check("inst_word", inst, mq[0] ^ K);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misaligned", misaligned, m_halt);
`endif
    if (redir) begin
      mq.delete();
      m_inflight = 0;
      m_pc       = rpc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_halt     = (rpc[1:0] != 2'b00);
`endif
    end else begin
      if (exp_pop)    void'(mq.pop_front());
      if (m_inflight) mq.push_back(m_inflight_pc);
      m_inflight    = exp_ren;
      m_inflight_pc = m_pc;
      if (exp_ren) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rpc;
    bit          rd;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ren", ren, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misaligned", misaligned, 1'b0);
`endif
    release_rst();

    // Streaming from reset with decode always ready.
    step(0, 0, 1);
    check("first_req_ren", s_ren, 1'b1);
    check("first_req_addr", s_raddr, 32'h0);
    step(0, 0, 1);
    check("lat_not_yet", s_valid, 1'b0);
    step(0, 0, 1);
    check("lat_valid", s_valid, 1'b1);
    check("lat_pc", s_pc, 32'h0);
    check("lat_inst", s_inst, 32'hA5A5_0000);
    for (int i = 0; i < 5; i++) step(0, 0, 1);

    // Redirect with data buffered and a read outstanding.
    step(0, 0, 0);
    step(1, 32'h0000_0100, 1);
    check("redir_t_ren", s_ren, 1'b0);
    step(0, 0, 1);
    check("redir_t1_ren", s_ren, 1'b1);
    check("redir_t1_addr", s_raddr, 32'h100);
    step(0, 0, 1);
    check("redir_t2_valid", s_valid, 1'b0);
    step(0, 0, 1);
    check("redir_t3_valid", s_valid, 1'b1);
    check("redir_t3_pc", s_pc, 32'h100);
    step(0, 0, 1);

    // Asynchronous reset with a read outstanding.
    #2 rst = 1'b1;
    #1;
    check("arst_ren", ren, 1'b0);
    check("arst_valid", valid, 1'b0);
    check("arst_inst_pc", inst_pc, 32'h0);
    model_reset();
    release_rst();

    // Backpressure straight after reset.
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    check("bp_ren", s_ren, 1'b0);
    check("bp_pc_frozen", s_raddr, 32'h8);
    check("bp_head_pc", s_pc, 32'h0);
    step(0, 0, 1);
    check("bp_out0", s_pc, 32'h0);
    step(0, 0, 1);
    check("bp_out1", s_pc, 32'h4);
    step(0, 0, 1);
    check("bp_out2", s_pc, 32'h8);

    // Misaligned redirect.
    step(1, 32'h0000_0102, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      check("mis_halt_ren", s_ren, 1'b0);
      check("mis_flag", misaligned, 1'b1);
    end
    step(1, 32'h0000_0200, 1);
    step(0, 0, 1);
    check("mis_resume_addr", s_raddr, 32'h200);
    check("mis_resume_ren", s_ren, 1'b1);
`else
    step(0, 0, 1);
    check("mis_clr_ren", s_ren, 1'b1);
    check("mis_clr_addr", s_raddr, 32'h100);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rd  = ($urandom_range(0, 19) == 0);
      rpc = $urandom_range(0, 4095);
      if ($urandom_range(0, 3) != 0) rpc = rpc & 32'hFFFF_FFFC;
      step(rd, rpc, ($urandom_range(0, 3) != 0));
    end
    step(1, 32'h0000_0400, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    // PC wrap instance, captured during the first stream.
    check("wrap_count", wcap.size(), 32'd3);
    check("wrap_pc0", (wcap.size() > 0) ? wcap[0] : 32'hxxxx_xxxx, 32'hFFFF_FFF8);
    check("wrap_pc1", (wcap.size() > 1) ? wcap[1] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
    check("wrap_pc2", (wcap.size() > 2) ? wcap[2] : 32'hxxxx_xxxx, 32'h0000_0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
